// File: rtl/seq_chunk_sub.sv
// ----------------------------------------------------------------------------
// seq_chunk_sub
//   Multi-cycle subtractor computing diff = a - b - bin over WIDTH bits.
//   CHUNK bits are processed per clock. The borrow ripples between chunks
//   through a register, so a full result takes NCHUNK = WIDTH/CHUNK compute
//   cycles. Optional unsigned saturation clamps the result to 0 when the
//   final borrow is set. A zero flag reports the post-saturation result.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operands present on a/b/bin/sat
//   in_ready   block can accept operands (IDLE only)
//   a, b       minuend / subtrahend, WIDTH bits
//   bin        borrow-in
//   sat        1 = clamp result to 0 on final borrow
//   out_valid  result available (DONE)
//   out_ready  consumer accepts result
//   diff       result, WIDTH bits
//   bout       final borrow-out (a < b + bin, unsigned)
//   zero       diff == 0 after saturation
// ----------------------------------------------------------------------------
module seq_chunk_sub #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   input  logic             sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             zero
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

   generate
      if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
         $error("seq_chunk_sub: WIDTH must be a positive multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   state_t           w_state_next;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_work;
   logic             r_sat;
   logic             r_borrow;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_diff;
   logic             r_bout;
   logic             r_zero;

   logic             w_accept;
   logic             w_last;
   logic [CHUNK:0]   w_sub;
   logic [WIDTH-1:0] w_work_next;
   logic [WIDTH-1:0] w_final;

   // Unsigned clamp: a final borrow with saturation enabled forces zero.
   function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] d,
                                                 input logic             en,
                                                 input logic             br);
      return (en && br) ? '0 : d;
   endfunction

   // Operands are shifted right each RUN cycle, so the active slice is
   // always in the low CHUNK bits. Result slices enter at the top of
   // r_work and shift down; after NCHUNK cycles slice 0 sits at bit 0.
   always_comb begin
      w_sub       = {1'b0, r_a[CHUNK-1:0]} - {1'b0, r_b[CHUNK-1:0]}
                    - {{CHUNK{1'b0}}, r_borrow};
      w_work_next = (r_work >> CHUNK)
                    | (WIDTH'(w_sub[CHUNK-1:0]) << (WIDTH - CHUNK));
      w_final     = saturate(w_work_next, r_sat, w_sub[CHUNK]);
      w_last      = (r_cnt == LAST_CNT);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      w_accept     = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_accept     = 1'b1;
               w_state_next = S_RUN;
            end
         end
         S_RUN: begin
            if (w_last) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_work   <= '0;
         r_sat    <= 1'b0;
         r_borrow <= 1'b0;
         r_cnt    <= '0;
         r_diff   <= '0;
         r_bout   <= 1'b0;
         r_zero   <= 1'b0;
      end else if (w_accept) begin
         r_a      <= a;
         r_b      <= b;
         r_sat    <= sat;
         r_borrow <= bin;
         r_cnt    <= '0;
      end else if (r_state == S_RUN) begin
         r_a      <= r_a >> CHUNK;
         r_b      <= r_b >> CHUNK;
         r_work   <= w_work_next;
         r_borrow <= w_sub[CHUNK];
         r_cnt    <= r_cnt + 1'b1;
         // Outputs only change on the final slice, so they stay stable
         // through RUN and while DONE waits on out_ready.
         if (w_last) begin
            r_diff <= w_final;
            r_bout <= w_sub[CHUNK];
            r_zero <= (w_final == '0);
         end
      end
   end

   assign diff = r_diff;
   assign bout = r_bout;
   assign zero = r_zero;

endmodule

// File: tb/tb_seq_chunk_sub.sv
module tb_seq_chunk_sub;

   logic        clk;
   logic        rst_n;

   // 16-bit / 4-bit chunk instance
   logic        v16, r16, ov16, or16, bin16, sat16, bo16, z16;
   logic [15:0] a16, b16, d16;

   // 8-bit instances, shared inputs: w = CHUNK 8, s = CHUNK 1
   logic        v8, bin8, sat8, or8;
   logic [7:0]  a8, b8;
   logic        r8w, ov8w, bo8w, z8w;
   logic [7:0]  d8w;
   logic        r8s, ov8s, bo8s, z8s;
   logic [7:0]  d8s;

   int total = 0;
   int bad   = 0;

   seq_chunk_sub #(.WIDTH(16), .CHUNK(4)) u_d16 (
      .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(r16),
      .a(a16), .b(b16), .bin(bin16), .sat(sat16),
      .out_valid(ov16), .out_ready(or16), .diff(d16), .bout(bo16), .zero(z16));

   seq_chunk_sub #(.WIDTH(8), .CHUNK(8)) u_d8w (
      .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8w),
      .a(a8), .b(b8), .bin(bin8), .sat(sat8),
      .out_valid(ov8w), .out_ready(or8), .diff(d8w), .bout(bo8w), .zero(z8w));

   seq_chunk_sub #(.WIDTH(8), .CHUNK(1)) u_d8s (
      .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8s),
      .a(a8), .b(b8), .bin(bin8), .sat(sat8),
      .out_valid(ov8s), .out_ready(or8), .diff(d8s), .bout(bo8s), .zero(z8s));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // Reference: plain integer subtraction, borrow when the true result is
   // negative, wrap modulo 2^w, then optional clamp to zero.
   task automatic model(input int w, input int a, input int b, input int bi, input int s,
                        output int d, output int bo, output int z);
      int t;
      t  = a - b - bi;
      bo = (t < 0) ? 1 : 0;
      if (t < 0) t = t + (1 << w);
      if (s != 0 && bo != 0) t = 0;
      d = t;
      z = (t == 0) ? 1 : 0;
   endtask

   task automatic accept16(input logic [15:0] a, input logic [15:0] b, input logic bi, input logic s);
      a16 = a; b16 = b; bin16 = bi; sat16 = s; v16 = 1'b1;
      chk("in_ready_before_accept", 32'(r16), 32'd1);
      tick;
      v16   = 1'b0;
      a16   = 16'($urandom);
      b16   = 16'($urandom);
      bin16 = 1'($urandom);
      sat16 = 1'($urandom);
   endtask

   // Called right after the accept edge; counts edges until out_valid.
   task automatic result16(input string tag, input int a, input int b, input int bi, input int s);
      int lat, ed, ebo, ez;
      model(16, a, b, bi, s, ed, ebo, ez);
      lat = 0;
      while (ov16 !== 1'b1 && lat < 20) begin
         tick;
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'd4);
      chk({tag, "_diff"}, 32'(d16), 32'(ed));
      chk({tag, "_bout"}, 32'(bo16), 32'(ebo));
      chk({tag, "_zero"}, 32'(z16), 32'(ez));
      chk({tag, "_in_ready_done"}, 32'(r16), 32'd0);
   endtask

   task automatic release16(input string tag);
      or16 = 1'b1;
      tick;
      or16 = 1'b0;
      chk({tag, "_out_valid_after_hs"}, 32'(ov16), 32'd0);
      chk({tag, "_in_ready_after_hs"}, 32'(r16), 32'd1);
   endtask

   task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic bi, input logic s);
      accept16(a, b, bi, s);
      result16(tag, int'(a), int'(b), int'(bi), int'(s));
      release16(tag);
   endtask

   initial begin
      int ed, ebo, ez, latw, lats;
      logic [7:0] cdw, cds;
      logic       cbw, czw, cbs, czs;
      logic [15:0] ra, rb;
      logic        rbi, rs;

      rst_n = 1'b0;
      v16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0; sat16 = 1'b0;
      v8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0; bin8 = 1'b0; sat8 = 1'b0;
      tick;
      tick;
      chk("rst_in_ready", 32'(r16), 32'd1);
      chk("rst_out_valid", 32'(ov16), 32'd0);
      chk("rst_diff", 32'(d16), 32'd0);
      chk("rst_bout", 32'(bo16), 32'd0);
      chk("rst_zero", 32'(z16), 32'd0);
      chk("rst_8_ready", 32'({r8w, r8s}), 32'd3);
      chk("rst_8_valid", 32'({ov8w, ov8s}), 32'd0);
      rst_n = 1'b1;
      tick;

      // out_ready asserted while IDLE must not disturb anything
      or16 = 1'b1;
      tick;
      or16 = 1'b0;
      chk("idle_out_ready_noeffect", 32'({r16, ov16}), 32'd2);

      op16("basic",       16'h1234, 16'h0234, 1'b0, 1'b0);
      op16("underflow",   16'h0000, 16'h0001, 1'b0, 1'b0);
      op16("underflow_sat", 16'h0000, 16'h0001, 1'b0, 1'b1);
      op16("ripple_bin1", 16'h8000, 16'h8000, 1'b1, 1'b0);
      op16("ripple_bin0", 16'h8000, 16'h8000, 1'b0, 1'b0);
      op16("max_minus_0", 16'hFFFF, 16'h0000, 1'b1, 1'b1);

      for (int n = 0; n < 40; n++) begin
         ra = 16'($urandom); rb = 16'($urandom);
         rbi = 1'($urandom); rs = 1'($urandom);
         op16("rand16", ra, rb, rbi, rs);
      end

      // Backpressure: hold DONE for 5 cycles with a new request pending
      accept16(16'h4321, 16'h1111, 1'b0, 1'b0);
      result16("bp1", 32'h4321, 32'h1111, 0, 0);
      a16 = 16'h00FF; b16 = 16'h0100; bin16 = 1'b0; sat16 = 1'b1; v16 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick;
         chk("bp_hold_valid", 32'(ov16), 32'd1);
         chk("bp_hold_in_ready", 32'(r16), 32'd0);
         chk("bp_hold_diff", 32'(d16), 32'h3210);
         chk("bp_hold_bout", 32'(bo16), 32'd0);
         chk("bp_hold_zero", 32'(z16), 32'd0);
      end
      or16 = 1'b1;
      tick;
      or16 = 1'b0;
      chk("bp_hs_valid", 32'(ov16), 32'd0);
      chk("bp_hs_not_accepted", 32'(r16), 32'd1);
      tick;
      chk("bp_accept_next_cycle", 32'(r16), 32'd0);
      v16 = 1'b0;
      a16 = 16'($urandom); b16 = 16'($urandom);
      result16("bp2", 32'h00FF, 32'h0100, 0, 1);
      release16("bp2");

      // Reset while on the second RUN cycle
      accept16(16'h5555, 16'h1111, 1'b0, 1'b0);
      tick;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      chk("midrst_in_ready", 32'(r16), 32'd1);
      chk("midrst_out_valid", 32'(ov16), 32'd0);
      chk("midrst_diff", 32'(d16), 32'd0);
      chk("midrst_bout", 32'(bo16), 32'd0);
      chk("midrst_zero", 32'(z16), 32'd0);
      for (int i = 0; i < 10; i++) begin
         tick;
         chk("midrst_no_spurious_valid", 32'(ov16), 32'd0);
      end
      op16("after_reset", 16'hABCD, 16'h0BCD, 1'b0, 1'b0);

      // Parameter sweep: CHUNK==WIDTH and bit-serial, same vectors
      for (int n = 0; n < 1000; n++) begin
         a8 = 8'($urandom); b8 = 8'($urandom);
         bin8 = 1'($urandom); sat8 = 1'($urandom);
         model(8, int'(a8), int'(b8), int'(bin8), int'(sat8), ed, ebo, ez);
         chk("sweep_ready", 32'({r8w, r8s}), 32'd3);
         v8 = 1'b1;
         tick;
         v8 = 1'b0;
         a8 = 8'($urandom); b8 = 8'($urandom);
         latw = 0; lats = 0;
         cdw = '0; cbw = 1'b0; czw = 1'b0; cds = '0; cbs = 1'b0; czs = 1'b0;
         for (int k = 1; k <= 12; k++) begin
            tick;
            if (ov8w === 1'b1 && latw == 0) begin
               latw = k; cdw = d8w; cbw = bo8w; czw = z8w;
            end
            if (ov8s === 1'b1 && lats == 0) begin
               lats = k; cds = d8s; cbs = bo8s; czs = z8s;
            end
         end
         chk("w8c8_latency", 32'(latw), 32'd1);
         chk("w8c8_diff", 32'(cdw), 32'(ed));
         chk("w8c8_bout", 32'(cbw), 32'(ebo));
         chk("w8c8_zero", 32'(czw), 32'(ez));
         chk("w8c1_latency", 32'(lats), 32'd8);
         chk("w8c1_diff", 32'(cds), 32'(ed));
         chk("w8c1_bout", 32'(cbs), 32'(ebo));
         chk("w8c1_zero", 32'(czs), 32'(ez));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
